// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings and the transmitter state encoding.
// The TX serializer, its mirror and the RX block all import this package.
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ  = 12_000_000;
    localparam int unsigned DEFAULT_UART_BAUD = 9600;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready byte-stream handshake; the producer side is the master and the
// buffer that stores the data is the slave.
interface uart_tx_fifo_if #(
    parameter int WIDTH = 8
) ();

    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a valid/ready write side and a show-ahead read side.
// A write is refused while full, even if a read frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    uart_tx_fifo_if.slave            wr_if,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full      = (r_count == FULL_CNT);
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_rd_data   = r_mem[r_rd_ptr];
    assign wr_if.ready = !o_full;

    assign w_push = wr_if.valid && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; an emptied FIFO never exposes stale entries,
    // and leaving it out keeps the array mappable to RAM.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_if.data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a sync_fifo and are shifted out
// LSB first, back to back with no idle gap while the buffer holds data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int unsigned UART_BAUD  = DEFAULT_UART_BAUD,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        ICE_CLK,
    input  logic                        RST,
    input  logic                        in_valid,
    input  logic [7:0]                  in_byte,
    output logic                        in_ready,
    output logic                        UART_TX,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned       CLKS_PER_BIT = CLK_FREQ / UART_BAUD;
    localparam int                BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);

    uart_tx_fifo_if #(.WIDTH(8)) w_in_if ();

    logic [7:0] w_rd_data;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;

    assign w_in_if.valid = in_valid;
    assign w_in_if.data  = in_byte;
    assign in_ready      = w_in_if.ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (ICE_CLK),
        .i_rst     (RST),
        .wr_if     (w_in_if),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (fifo_count)
    );

    tx_state_e         r_state,  w_state_next;
    logic [BAUD_W-1:0] r_baud,   w_baud_next;
    logic [2:0]        r_bit,    w_bit_next;
    logic [7:0]        r_shift,  w_shift_next;
    logic              r_tx,     w_tx_next;
    logic              r_tx_done, w_done_next;
    logic              w_baud_end;

    assign w_baud_end = (r_baud == BAUD_LAST);

    // NOTE: every signal gets its default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        w_done_next  = 1'b0;

        case (r_state)
            TX_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_rd_data;
                    w_state_next = TX_START;
                end
            end
            TX_START: begin
                w_tx_next = 1'b0;
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                    w_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                w_tx_next = r_shift[r_bit];
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_bit == 3'd7) w_state_next = TX_STOP;
                    else               w_bit_next   = r_bit + 3'd1;
                end
            end
            TX_STOP: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    w_done_next = 1'b1;
                    // Chain straight into the next start bit when more data waits.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_rd_data;
                        w_state_next = TX_START;
                    end else begin
                        w_state_next = TX_IDLE;
                    end
                end
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements run in.
    always_ff @(posedge ICE_CLK) begin
        if (RST) begin
            r_state   <= TX_IDLE;
            r_baud    <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_tx_done <= w_done_next;
        end
    end

    assign UART_TX = r_tx;
    assign tx_done = r_tx_done;
    assign busy    = (r_state != TX_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at 16 clocks per bit: a frame-level
// reference model is compared every cycle, plus hand-computed frame checks.
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_tx;
    logic       busy;
    logic       tx_done;
    logic [4:0] fifo_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.WIDTH(8)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ   (16),
        .UART_BAUD  (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .ICE_CLK    (clk),
        .RST        (rst),
        .in_valid   (bus.valid),
        .in_byte    (bus.data),
        .in_ready   (bus.ready),
        .UART_TX    (uart_tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the number of clocks left in the frame
    // being sent; the line shows the frame one clock behind the frame timer.
    logic [7:0] q[$];
    int         ser_rem  = 0;
    logic [7:0] frame_byte = 8'h00;
    logic       exp_tx   = 1'b1;
    logic       exp_done = 1'b0;
    logic       model_ok = 1'b0;

    always @(posedge clk) begin
        logic do_push;
        logic do_pop;
        int   pos;
        if (rst) begin
            q.delete();
            ser_rem  = 0;
            exp_tx   = 1'b1;
            exp_done = 1'b0;
            model_ok = 1'b1;
        end else begin
            do_push = bus.valid && (q.size() != DEPTH);
            do_pop  = (q.size() != 0) && (ser_rem <= 1);
            if (ser_rem > 0) begin
                pos      = (FRAME - ser_rem) / CPB;
                exp_tx   = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : frame_byte[pos-1];
                exp_done = (ser_rem == 1);
            end else begin
                exp_tx   = 1'b1;
                exp_done = 1'b0;
            end
            if (do_pop) begin
                frame_byte = q.pop_front();
                ser_rem    = FRAME;
            end else if (ser_rem > 0) begin
                ser_rem--;
            end
            if (do_push) q.push_back(bus.data);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("uart_tx",    uart_tx,    exp_tx);
            check("tx_done",    tx_done,    exp_done);
            check("busy",       busy,       (ser_rem != 0) || (q.size() != 0));
            check("fifo_count", fifo_count, q.size());
            check("in_ready",   bus.ready,  q.size() != DEPTH);
        end
    end

    // Push one byte from an idle block and compare the line against a literal frame.
    task automatic send_and_check_frame(input logic [7:0] b, input logic bits[8], input string tag);
        int   bad_cycles = 0;
        int   pulses     = 0;
        int   pulse_at   = -1;
        logic exp;
        bus.valid = 1'b1;
        bus.data  = b;
        @(negedge clk);
        bus.valid = 1'b0;
        bus.data  = 8'($urandom);
        for (int i = 1; i <= 162; i++) begin
            @(negedge clk);
            if (i < 2)        exp = 1'b1;
            else if (i < 18)  exp = 1'b0;
            else if (i < 146) exp = bits[(i - 18) / CPB];
            else              exp = 1'b1;
            if (uart_tx !== exp) bad_cycles++;
            if (tx_done === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
        end
        check({tag, "_line_bad_cycles"}, bad_cycles, 0);
        check({tag, "_done_pulses"}, pulses, 1);
        check({tag, "_done_cycle"}, pulse_at, 161);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic wait_idle(input int bound, output int pulses);
        pulses = 0;
        for (int c = 0; c < bound; c++) begin
            if (tx_done === 1'b1) pulses++;
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        check("wait_idle_busy", busy, 0);
    endtask

    logic a5_bits[8];
    logic c3c_bits[8];

    initial begin
        int idx;
        int pulses;
        int drain_pulses;
        int busy_hi;
        int prev_cnt;
        int full_ready_bad;
        logic saw_full;
        logic saw_drop;
        logic rdy;
        int pct;

        a5_bits  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        c3c_bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bus.valid = 1'b0;
        bus.data  = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_in_ready", bus.ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;
        @(negedge clk);

        send_and_check_frame(8'hA5, a5_bits, "a5");

        // Three back-to-back bytes: busy must hold for 481 samples from the first push.
        bus.valid = 1'b1;
        bus.data  = 8'h00;
        @(negedge clk);
        busy_hi = 0;
        pulses  = 0;
        for (int i = 0; i < 520; i++) begin
            if (busy === 1'b1) busy_hi++;
            if (tx_done === 1'b1) pulses++;
            if (i == 0) bus.data = 8'hFF;
            if (i == 1) bus.data = 8'h55;
            if (i == 2) bus.valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_busy_cycles", busy_hi, 481);
        check("b2b_done_pulses", pulses, 3);

        // Hold in_valid with 20 distinct bytes through a full buffer.
        idx = 0;
        pulses = 0;
        prev_cnt = -1;
        full_ready_bad = 0;
        saw_full = 1'b0;
        saw_drop = 1'b0;
        for (int cyc = 0; cyc < 4000 && idx < 20; cyc++) begin
            if (tx_done === 1'b1) pulses++;
            if (fifo_count == 5'd16) begin
                saw_full = 1'b1;
                if (bus.ready !== 1'b0) full_ready_bad++;
            end
            if (prev_cnt == 16 && fifo_count == 5'd15) saw_drop = 1'b1;
            prev_cnt  = int'(fifo_count);
            bus.valid = 1'b1;
            bus.data  = 8'(8'h40 + idx);
            rdy       = bus.ready;
            @(negedge clk);
            if (rdy) idx++;
        end
        bus.valid = 1'b0;
        check("fill_accepted", idx, 20);
        check("fill_reached_full", saw_full, 1);
        check("fill_ready_low_when_full", full_ready_bad, 0);
        check("full_pop_16_to_15", saw_drop, 1);
        wait_idle(20 * FRAME + 50, drain_pulses);
        check("fill_done_pulses", pulses + drain_pulses, 20);

        // Random traffic at a light and a heavy offered load.
        for (int phase = 0; phase < 2; phase++) begin
            pct = (phase == 0) ? 4 : 60;
            for (int c = 0; c < 1200; c++) begin
                bus.valid = ($urandom_range(0, 99) < pct);
                bus.data  = 8'($urandom);
                @(negedge clk);
            end
            bus.valid = 1'b0;
            wait_idle(20 * FRAME + 50, drain_pulses);
        end

        // Reset during data bit 3 of 0xC3 with a second byte still buffered.
        bus.valid = 1'b1;
        bus.data  = 8'hC3;
        @(negedge clk);
        bus.data  = 8'h99;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (70) @(negedge clk);
        check("pre_reset_bit3_low", uart_tx, 0);
        check("pre_reset_count", fifo_count, 1);
        rst       = 1'b1;
        bus.valid = 1'b1;
        bus.data  = 8'hEE;
        @(negedge clk);
        check("mid_rst_uart_tx", uart_tx, 1);
        check("mid_rst_fifo_count", fifo_count, 0);
        check("mid_rst_in_ready", bus.ready, 1);
        check("mid_rst_busy", busy, 0);
        rst       = 1'b0;
        bus.valid = 1'b0;
        @(negedge clk);
        send_and_check_frame(8'h3C, c3c_bits, "after_rst_3c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        bad++;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
